// File: rtl/qmem_addr_decoder_if.sv
// qmem bus bundle around the address decoder: the master-facing request port and
// the per-slave fan-out (SN slaves, fields packed slave-major).
interface qmem_addr_decoder_if #(
  parameter int QAW = 32,
  parameter int QDW = 32,
  parameter int QSW = QDW / 8,
  parameter int SN  = 4
);
  // Handshake: the requester holds cs together with we/adr/sel/dat_w stable until a
  // cycle in which ack or err is high; that cycle ends the transfer. Read data
  // belonging to an ack appears on dat_r in the following cycle.
  logic                 qm_cs;
  logic                 qm_we;
  logic [QAW-1:0]       qm_adr;
  logic [QSW-1:0]       qm_sel;
  logic [QDW-1:0]       qm_dat_w;
  logic [QDW-1:0]       qm_dat_r;
  logic                 qm_ack;
  logic                 qm_err;

  logic [SN-1:0]        qs_cs;
  logic [SN-1:0]        qs_we;
  logic [SN*QAW-1:0]    qs_adr;
  logic [SN*QSW-1:0]    qs_sel;
  logic [SN*QDW-1:0]    qs_dat_w;
  logic [SN*QDW-1:0]    qs_dat_r;
  logic [SN-1:0]        qs_ack;
  logic [SN-1:0]        qs_err;

  // Decoder seen as a slave by the CPU-side master.
  modport slave (
    input  qm_cs, qm_we, qm_adr, qm_sel, qm_dat_w,
    output qm_dat_r, qm_ack, qm_err
  );

  // Decoder seen as the master of the slave fan-out.
  modport master (
    output qs_cs, qs_we, qs_adr, qs_sel, qs_dat_w,
    input  qs_dat_r, qs_ack, qs_err
  );
endinterface

// File: rtl/qmem_addr_decoder.sv
// qmem 1-to-SN address decoder with base/mask map, decode-error termination and
// an optional stall watchdog enabled by QMEM_ADDR_DECODER_WATCHDOG_EN.
module qmem_addr_decoder #(
  parameter int              QAW     = 32,
  parameter int              QDW     = 32,
  parameter int              QSW     = QDW / 8,
  parameter int              SN      = 4,
  parameter logic [SN*QAW-1:0] BASE  = '0,
  parameter logic [SN*QAW-1:0] MASK  = '0,
  parameter logic [31:0]     ERR_DAT = 32'hdead_beef,
  parameter int              TO_CYC  = 256,
  parameter int              TOW     = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  qmem_addr_decoder_if.slave    m_bus,
  qmem_addr_decoder_if.master   s_bus,
  output logic                  dec_err,
  output logic                  to_err,
  output logic [QAW-1:0]        err_adr,
  output logic [1:0]            dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DERR = 2'd1,
    S_TERR = 2'd2
  } state_e;

  localparam int               RSW      = $clog2(SN + 1);
  localparam logic [RSW-1:0]   RSEL_ERR = RSW'(SN);

  state_e           state_q, state_d;
  logic [RSW-1:0]   rsel_q;
  logic [QAW-1:0]   err_adr_q;

  logic [SN-1:0]    hit;
  logic [SN-1:0]    first_hit;
  logic             any_hit;
  logic [RSW-1:0]   idx;
  logic             req_hit;

  logic [SN-1:0]    cs_nxt;
  logic             ack_nxt;
  logic             err_nxt;
  logic             dec_nxt;
  logic             to_nxt;

`ifdef QMEM_ADDR_DECODER_WATCHDOG_EN
  logic [TOW-1:0]   wcnt_q, wcnt_d;
`endif

  // Lowest-index matching region wins, so a catch-all slave can sit at a high index.
  always_comb begin
    hit       = '0;
    first_hit = '0;
    idx       = RSEL_ERR;
    for (int i = 0; i < SN; i++) begin
      hit[i] = ((m_bus.qm_adr ^ BASE[QAW*i +: QAW]) & MASK[QAW*i +: QAW]) == '0;
    end
    for (int i = SN - 1; i >= 0; i--) begin
      if (hit[i]) begin
        first_hit = '0;
        first_hit[i] = 1'b1;
        idx = RSW'(i);
      end
    end
  end

  assign any_hit = |hit;
  assign req_hit = m_bus.qm_cs & any_hit;

  always_comb begin
    state_d = state_q;
    cs_nxt  = '0;
    ack_nxt = 1'b0;
    err_nxt = 1'b0;
    dec_nxt = 1'b0;
    to_nxt  = 1'b0;
`ifdef QMEM_ADDR_DECODER_WATCHDOG_EN
    wcnt_d  = '0;
`endif
    case (state_q)
      S_IDLE: begin
        cs_nxt  = req_hit ? first_hit : '0;
        ack_nxt = req_hit & |(first_hit & s_bus.qs_ack);
        err_nxt = req_hit & |(first_hit & s_bus.qs_err);
`ifdef QMEM_ADDR_DECODER_WATCHDOG_EN
        if (req_hit && !ack_nxt && !err_nxt) begin
          wcnt_d = wcnt_q + 1'b1;
        end
`endif
        if (m_bus.qm_cs && !any_hit) begin
          state_d = S_DERR;
        end
`ifdef QMEM_ADDR_DECODER_WATCHDOG_EN
        // A response in the last allowed cycle clears wcnt_d first, so ack beats expiry.
        else if (wcnt_d == TOW'(TO_CYC)) begin
          state_d = S_TERR;
        end
`endif
      end
      S_DERR: begin
        err_nxt = 1'b1;
        dec_nxt = 1'b1;
        state_d = S_IDLE;
      end
`ifdef QMEM_ADDR_DECODER_WATCHDOG_EN
      S_TERR: begin
        err_nxt = 1'b1;
        to_nxt  = 1'b1;
        state_d = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
    if (rst) begin
      cs_nxt  = '0;
      ack_nxt = 1'b0;
      err_nxt = 1'b0;
      dec_nxt = 1'b0;
      to_nxt  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rsel_q    <= RSEL_ERR;
      err_adr_q <= '0;
    end else begin
      state_q <= state_d;
      if (m_bus.qm_cs && !m_bus.qm_we) begin
        if (err_nxt) begin
          rsel_q <= RSEL_ERR;
        end else if (ack_nxt) begin
          rsel_q <= idx;
        end
      end
      if (state_q == S_IDLE && state_d != S_IDLE) begin
        err_adr_q <= m_bus.qm_adr;
      end
    end
  end

`ifdef QMEM_ADDR_DECODER_WATCHDOG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt_q <= '0;
    end else begin
      wcnt_q <= wcnt_d;
    end
  end
  assign to_err = to_nxt;
`else
  assign to_err = 1'b0;
`endif

  always_comb begin
    m_bus.qm_dat_r = QDW'(ERR_DAT);
    for (int i = 0; i < SN; i++) begin
      if (rsel_q == RSW'(i)) begin
        m_bus.qm_dat_r = s_bus.qs_dat_r[QDW*i +: QDW];
      end
    end
  end

  assign m_bus.qm_ack   = ack_nxt;
  assign m_bus.qm_err   = err_nxt;
  assign s_bus.qs_cs    = cs_nxt;
  assign s_bus.qs_we    = {SN{m_bus.qm_we}};
  assign s_bus.qs_adr   = {SN{m_bus.qm_adr}};
  assign s_bus.qs_sel   = {SN{m_bus.qm_sel}};
  assign s_bus.qs_dat_w = {SN{m_bus.qm_dat_w}};
  assign dec_err        = dec_nxt;
  assign err_adr        = err_adr_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_qmem_addr_decoder.sv
// Self-checking bench for qmem_addr_decoder: directed map/latency/error/reset steps
// followed by randomized transfers checked against an address-map reference model.
module tb_qmem_addr_decoder;
  localparam int QAW    = 32;
  localparam int QDW    = 32;
  localparam int QSW    = 4;
  localparam int SN     = 4;
  localparam int TO_CYC = 16;
  localparam int TOW    = 5;
  localparam logic [31:0] ERR_DAT = 32'hdead_beef;

  // Slave 3 covers 0x0000_0000..0x07FF_FFFF so 0x0F00_0000 stays unmapped.
  localparam logic [SN*QAW-1:0] BASE = {32'h0000_0000, 32'h0200_0000, 32'h0100_0000, 32'h0000_0000};
  localparam logic [SN*QAW-1:0] MASK = {32'hF800_0000, 32'hFF00_0000, 32'hFF00_0000, 32'hFF00_0000};

  // Reference map: region i = all addresses whose top bits match the region prefix.
  logic [31:0] m_lo [SN] = '{32'h0000_0000, 32'h0100_0000, 32'h0200_0000, 32'h0000_0000};
  logic [31:0] m_hi [SN] = '{32'h00FF_FFFF, 32'h01FF_FFFF, 32'h02FF_FFFF, 32'h07FF_FFFF};

  logic clk;
  logic rst;
  logic dec_err, to_err;
  logic [QAW-1:0] err_adr;
  logic [1:0] dbg_state;

  logic [QDW-1:0] slave_data [SN];
  logic [31:0] exp_q [$];
  int n_tests = 0;
  int n_fail  = 0;
  int m_rsel  = SN;

  qmem_addr_decoder_if #(.QAW(QAW), .QDW(QDW), .QSW(QSW), .SN(SN)) bus ();

  qmem_addr_decoder #(
    .QAW(QAW), .QDW(QDW), .QSW(QSW), .SN(SN), .BASE(BASE), .MASK(MASK),
    .ERR_DAT(ERR_DAT), .TO_CYC(TO_CYC), .TOW(TOW)
  ) dut (
    .clk(clk), .rst(rst), .m_bus(bus.slave), .s_bus(bus.master),
    .dec_err(dec_err), .to_err(to_err), .err_adr(err_adr), .dbg_state_o(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < SN; i++) bus.qs_dat_r[QDW*i +: QDW] = slave_data[i];
  end

  function automatic int ref_idx(input logic [31:0] a);
    for (int i = 0; i < SN; i++) begin
      if (a >= m_lo[i] && a <= m_hi[i]) return i;
    end
    return SN;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic [SN-1:0] cs, input logic ack,
                            input logic err, input logic de, input logic te);
    @(negedge clk);
    chk({tag, ".qs_cs"}, bus.qs_cs, cs);
    chk({tag, ".qm_ack"}, bus.qm_ack, ack);
    chk({tag, ".qm_err"}, bus.qm_err, err);
    chk({tag, ".dec_err"}, dec_err, de);
    chk({tag, ".to_err"}, to_err, te);
  endtask

  task automatic idle_check(input string tag);
    exp_q.push_back(m_rsel == SN ? ERR_DAT : slave_data[m_rsel]);
    check_outs({tag, ".idle"}, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk({tag, ".dat_r"}, bus.qm_dat_r, exp_q.pop_front());
    tick();
  endtask

  // One complete transfer; lat = wait cycles before the slave responds.
  task automatic do_xfer(input string tag, input logic [31:0] a, input logic we,
                         input int lat, input logic use_err);
    int ei;
    logic [SN-1:0] ecs;
    ei = ref_idx(a);
    bus.qm_cs    = 1'b1;
    bus.qm_we    = we;
    bus.qm_adr   = a;
    bus.qm_sel   = QSW'($urandom);
    bus.qm_dat_w = $urandom;
    if (ei == SN) begin
      check_outs({tag, ".miss0"}, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      check_outs({tag, ".miss1"}, '0, 1'b0, 1'b1, 1'b1, 1'b0);
      tick();
      bus.qm_cs = 1'b0;
      if (!we) m_rsel = SN;
      chk({tag, ".err_adr"}, err_adr, a);
    end else begin
      ecs = '0;
      ecs[ei] = 1'b1;
      for (int c = 0; c <= lat; c++) begin
        if (c == lat) begin
          if (use_err) bus.qs_err[ei] = 1'b1;
          else         bus.qs_ack[ei] = 1'b1;
        end
        check_outs({tag, ".hit"}, ecs, (c == lat) && !use_err, (c == lat) && use_err, 1'b0, 1'b0);
        if (c == 0) begin
          chk({tag, ".bcast_adr"}, bus.qs_adr, {SN{a}});
          chk({tag, ".bcast_we"}, bus.qs_we, {SN{we}});
        end
        tick();
      end
      bus.qm_cs  = 1'b0;
      bus.qs_ack = '0;
      bus.qs_err = '0;
      if (!we) m_rsel = use_err ? SN : ei;
    end
    idle_check(tag);
  endtask

  initial begin
    logic [31:0] a;
    rst = 1'b1;
    bus.qm_cs = 1'b0; bus.qm_we = 1'b0; bus.qm_adr = '0; bus.qm_sel = '0; bus.qm_dat_w = '0;
    bus.qs_ack = '0; bus.qs_err = '0;
    for (int i = 0; i < SN; i++) slave_data[i] = 32'h1111_1111 * (i + 1);
    tick();
    tick();
    // Request plus slave ack during reset must not leak through.
    bus.qm_cs = 1'b1; bus.qm_adr = 32'h0000_0010; bus.qs_ack[0] = 1'b1;
    check_outs("reset", '0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b0; bus.qm_cs = 1'b0; bus.qs_ack = '0;
    @(negedge clk);
    chk("reset.dat_r", bus.qm_dat_r, ERR_DAT);
    chk("reset.err_adr", err_adr, 32'h0);
    tick();

    do_xfer("map_s1", 32'h0100_0010, 1'b0, 0, 1'b0);
    do_xfer("map_s3", 32'h0300_0000, 1'b0, 0, 1'b0);
    do_xfer("map_prio", 32'h0000_0004, 1'b0, 1, 1'b0);
    slave_data[2] = 32'h1234_5678;
    do_xfer("rd_s2_lat3", 32'h0200_0000, 1'b0, 3, 1'b0);
    do_xfer("unmapped", 32'h0F00_0000, 1'b0, 0, 1'b0);
    do_xfer("wr_slv_err", 32'h0000_0040, 1'b1, 2, 1'b1);
    do_xfer("rd_after_wr", 32'h0100_0000, 1'b0, 0, 1'b0);

`ifdef QMEM_ADDR_DECODER_WATCHDOG_EN
    bus.qm_cs = 1'b1; bus.qm_we = 1'b0; bus.qm_adr = 32'h0100_0000;
    for (int c = 0; c < TO_CYC; c++) begin
      check_outs("wd_wait", 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    check_outs("wd_expire", '0, 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    bus.qm_cs = 1'b0;
    m_rsel = SN;
    chk("wd.err_adr", err_adr, 32'h0100_0000);
    idle_check("wd");
    do_xfer("wd_ack_last", 32'h0100_0000, 1'b0, TO_CYC - 1, 1'b0);
`else
    do_xfer("no_wd_long", 32'h0100_0000, 1'b0, 40, 1'b0);
`endif

    // Reset in cycle 5 of a stalled read.
    bus.qm_cs = 1'b1; bus.qm_we = 1'b0; bus.qm_adr = 32'h0200_0004;
    for (int c = 0; c < 5; c++) begin
      check_outs("rst_wait", 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    rst = 1'b1;
    check_outs("rst_mid0", '0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check_outs("rst_mid1", '0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b0; bus.qm_cs = 1'b0;
    m_rsel = SN;
    for (int c = 0; c < TO_CYC + 4; c++) begin
      @(negedge clk);
      chk("rst_after.to_err", to_err, 1'b0);
      tick();
    end
    chk("rst_after.err_adr", err_adr, 32'h0);
    idle_check("rst_after");

    for (int n = 0; n < 60; n++) begin
      for (int i = 0; i < SN; i++) slave_data[i] = $urandom;
      case ($urandom_range(0, 4))
        0:       a = {8'h00, 24'($urandom)};
        1:       a = {8'h01, 24'($urandom)};
        2:       a = {8'h02, 24'($urandom)};
        3:       a = {5'($urandom_range(0, 31)), 27'($urandom)};
        default: a = $urandom;
      endcase
      do_xfer("rand", a, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
